// File: rtl/acc_pkg.sv
// Shared definitions for the block accumulator: state encoding and the
// saturating add used when ACC_SATURATE_EN is defined.
package acc_pkg;

  localparam logic ST_ACC  = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  typedef enum logic {
    S_ACC  = ST_ACC,
    S_HOLD = ST_HOLD
  } state_t;

  // Unsigned add of two width-bit values clamped to 2^width-1 (width <= 32).
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned width);
    logic [63:0] s;
    logic [63:0] mx;
    s  = {32'd0, a} + {32'd0, b};
    mx = (64'd1 << width) - 64'd1;
    return (s > mx) ? 32'(mx) : 32'(s);
  endfunction

endpackage

// File: rtl/acc_adder.sv
// Y_W-bit accumulator adder. Wraps modulo 2^Y_W by default; clamps at
// 2^Y_W-1 when ACC_SATURATE_EN is defined.
module acc_adder
  import acc_pkg::*;
#(
  parameter int Y_W = 6
) (
  input  logic [Y_W-1:0] a,
  input  logic [Y_W-1:0] b,
  output logic [Y_W-1:0] sum
);

`ifdef ACC_SATURATE_EN
  assign sum = Y_W'(sat_add(32'(a), 32'(b), Y_W));
`else
  assign sum = a + b;
`endif

endmodule

// File: rtl/block_accumulator.sv
// Sums up to N_SAMPLES accepted words per block with ready/valid on both
// sides; overflow mode selected by ACC_SATURATE_EN (see acc_adder).
module block_accumulator
  import acc_pkg::*;
#(
  parameter  int X_W       = 4,
  parameter  int Y_W       = 6,
  parameter  int N_SAMPLES = 4,
  localparam int CNT_W     = $clog2(N_SAMPLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [X_W-1:0]   x,
  input  logic             x_is_valid,
  input  logic             x_last,
  output logic             x_ready,
  output logic [Y_W-1:0]   y,
  output logic             y_is_valid,
  input  logic             y_ready,
  output logic [CNT_W-1:0] y_count
);

  state_t           state, state_nxt;
  logic [Y_W-1:0]   sum, sum_nxt, add_out, y_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, y_count_nxt;
  logic             y_valid_nxt;
  logic             accept, close_blk;

  acc_adder #(.Y_W(Y_W)) u_add (
    .a   (sum),
    .b   (Y_W'(x)),
    .sum (add_out)
  );

  assign x_ready   = (state == S_ACC) & ~rst;
  assign accept    = x_is_valid & x_ready;
  assign close_blk = (cnt == CNT_W'(N_SAMPLES - 1)) | x_last;

  always_comb begin
    state_nxt   = state;
    sum_nxt     = sum;
    cnt_nxt     = cnt;
    y_nxt       = y;
    y_count_nxt = y_count;
    y_valid_nxt = y_is_valid;
    if (state == S_ACC) begin
      if (accept) begin
        if (close_blk) begin
          y_nxt       = add_out;
          y_count_nxt = cnt + CNT_W'(1);
          y_valid_nxt = 1'b1;
          sum_nxt     = '0;
          cnt_nxt     = '0;
          state_nxt   = S_HOLD;
        end else begin
          sum_nxt = add_out;
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
    end else if (y_ready) begin
      // y and y_count keep their value after the handshake
      y_valid_nxt = 1'b0;
      state_nxt   = S_ACC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_ACC;
      sum        <= '0;
      cnt        <= '0;
      y          <= '0;
      y_count    <= '0;
      y_is_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      sum        <= sum_nxt;
      cnt        <= cnt_nxt;
      y          <= y_nxt;
      y_count    <= y_count_nxt;
      y_is_valid <= y_valid_nxt;
    end
  end

endmodule
